reg_writeback: RTL
==================

Name: reg_writeback

Overview:
- Register write-back bank for the 8-bit datapath. Holds r0..r3 and accepts result writes addressed by a 2-bit register select; this is the write end of the register access path.
- Writes enter through a valid/ready handshake into a small in-order FIFO.
- Queued writes commit to the bank one per cycle while commit_en is high.
- busy flags mark registers with a write still queued, so issue logic can detect hazards.

Parameters:
- WIDTH, 8, register/data width in bits.
- DEPTH, 2, write FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write request present.
- wr_ready  out  1  block can accept a request this cycle.
- wr_cmd  in  2  destination select: 00=r0, 01=r1, 10=r2, 11=r3.
- wr_data  in  WIDTH  value to write.
- commit_en  in  1  permits the FIFO head to commit this cycle.
- r0  out  WIDTH  register 0.
- r1  out  WIDTH  register 1.
- r2  out  WIDTH  register 2.
- r3  out  WIDTH  register 3.
- busy  out  4  busy[i]=1 while any queued entry targets register i.
- pending  out  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Reset:
  - rst_n low asynchronously clears r0..r3 to 0, empties the FIFO, and sets pending=0 and busy=0.
  - wr_ready=1 from the first edge after release.
  - Reset mid-operation discards all queued writes; none commit.
- Accept: a request is accepted on a rising edge when wr_valid && wr_ready. {wr_cmd, wr_data} are pushed at the write pointer.
- wr_ready = (pending != DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from commit_en.
- Commit:
  - On a rising edge with commit_en && pending != 0, the head entry's data is written to the selected register and the head is popped.
  - Only one commit per cycle.
- Latency:
  - A request accepted at edge N reaches the FIFO at edge N and can commit no earlier than edge N+1.
  - Into an empty FIFO with commit_en held high, a register output changes one cycle after acceptance.
- Simultaneous push and pop:
  - Allowed whenever pending is neither 0 nor DEPTH (pending == DEPTH blocks the push via wr_ready); pending is then unchanged.
  - With pending == 0, the push is taken and no pop occurs.
- Ordering: strictly in order. Repeated writes to the same register commit in acceptance order, so the last accepted write wins.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. pending tracks occupancy 0..DEPTH.
- busy is combinational from valid FIFO entries only. It deasserts on the edge that commits the last entry targeting that register.
- commit_en low freezes the registers and the FIFO head. Pushes continue until full.
- wr_data is not sign- or zero-extended; the width is WIDTH throughout.
- Register outputs are driven directly from flops, with no combinational bypass of queued data.

Optional Feature:
- Macro REG_WB_R0_ZERO_EN.
- Defined:
  - r0 is hard-wired to 0.
  - Requests with wr_cmd=00 are still accepted and queued to preserve ordering and pending count, but their commit is discarded.
  - busy[0] is forced to 0.
- Undefined: r0 is an ordinary writable register.

Decomposition:
- Shared package reg_pkg:
  - REG_W=8.
  - Register select constants REG_R0..REG_R3 (2'b00..2'b11).
  - wb_entry typedef {sel[1:0], data[REG_W-1:0]}.
- One sub-module, wb_fifo:
  - Parameterised synchronous FIFO: push, pop, full, empty, count, head, plus a per-entry valid/sel view for busy generation.
- reg_writeback owns the register flops, commit decode and busy reduction.

Test Plan:
- Reset release, then wr_valid=1, wr_cmd=10, wr_data=8'hA5, commit_en=1 -> wr_ready=1, busy[2]=1 for one cycle, r2=8'hA5 one cycle after accept, all other registers 0.
- commit_en=0, push r1=8'h11 then r3=8'h33 -> pending=2, wr_ready=0, busy=4'b1010. Third request held off. Raise commit_en -> r1 updates, then r3 on the next edge.
- Full FIFO with commit_en=1 and wr_valid=1 -> no push in the full cycle. Push accepted the following cycle while popping, pending stays at 1 and 2 as expected, and the pointers wrap correctly over 6 back-to-back writes.
- Writes r0=8'h01, r0=8'h02, r0=8'h03 back to back -> r0 steps 01, 02, 03 in order, final value 8'h03, busy[0] clears after the third commit.
- Queue two writes, pulse rst_n low mid-queue -> r0..r3=0 immediately (asynchronous), pending=0, no queued write commits after release.
- REG_WB_R0_ZERO_EN defined: write r0=8'hFF, commit -> r0 stays 0, pending returns to 0, busy[0] never asserts.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for the register write-back path: select codes,
// the queued-entry layout and a select decoder.
package reg_pkg;

   localparam int REG_W = 8;

   localparam logic [1:0] REG_R0 = 2'b00;
   localparam logic [1:0] REG_R1 = 2'b01;
   localparam logic [1:0] REG_R2 = 2'b10;
   localparam logic [1:0] REG_R3 = 2'b11;

   typedef struct packed {
      logic [1:0]       sel;
      logic [REG_W-1:0] data;
   } wb_entry;

   function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
      logic [3:0] oh;
      oh      = 4'b0000;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write FIFO for the write-back bank: pointers wrap modulo DEPTH,
// count tracks 0..DEPTH, and a per-entry valid/sel view feeds busy generation.
module wb_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [1:0]            i_push_sel,
   input  logic [WIDTH-1:0]      i_push_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [CNT_W-1:0]      o_count,
   output logic [1:0]            o_head_sel,
   output logic [WIDTH-1:0]      o_head_data,
   output logic [DEPTH-1:0]      o_ent_vld,
   output logic [DEPTH-1:0][1:0] o_ent_sel
);

   logic [1:0]       r_sel  [DEPTH];
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_off [DEPTH];

   assign o_full   = (r_count == CNT_W'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;

   // Guard internally so a caller can never corrupt occupancy.
   assign w_push   = i_push && !o_full;
   assign w_pop    = i_pop  && !o_empty;

   assign o_head_sel  = r_sel[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];

   // Storage carries no reset: only pointers and count decide validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_sel[r_wr_ptr]  <= i_push_sel;
         r_data[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Slot k is live when its distance from the read pointer is below count.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         w_off[k]     = PTR_W'(k) - r_rd_ptr;
         o_ent_vld[k] = ({1'b0, w_off[k]} < r_count);
         o_ent_sel[k] = r_sel[k];
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Write-back bank r0..r3 fed by an in-order write FIFO; commits one entry per
// cycle under commit_en. Build option REG_WB_R0_ZERO_EN makes r0 a constant zero.
module reg_writeback
   import reg_pkg::*;
#(
   parameter  int WIDTH = REG_W,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [1:0]       wr_cmd,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit_en,
   output logic [WIDTH-1:0] r0,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [3:0]       busy,
   output logic [CNT_W-1:0] pending
);

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [1:0]            w_head_sel;
   logic [WIDTH-1:0]      w_head_data;
   logic [DEPTH-1:0]      w_ent_vld;
   logic [DEPTH-1:0][1:0] w_ent_sel;
   logic [3:0]            w_busy;

   logic [WIDTH-1:0]      r_reg1;
   logic [WIDTH-1:0]      r_reg2;
   logic [WIDTH-1:0]      r_reg3;

   // Ready looks only at occupancy, keeping commit_en off the ready path.
   assign wr_ready = !w_full;
   assign w_push   = wr_valid && wr_ready;
   assign w_pop    = commit_en && !w_empty;

   wb_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_sel  (wr_cmd),
      .i_push_data (wr_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (pending),
      .o_head_sel  (w_head_sel),
      .o_head_data (w_head_data),
      .o_ent_vld   (w_ent_vld),
      .o_ent_sel   (w_ent_sel)
   );

`ifdef REG_WB_R0_ZERO_EN
   assign r0 = '0;
`else
   logic [WIDTH-1:0] r_reg0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg0 <= '0;
      end else if (w_pop && (w_head_sel == REG_R0)) begin
         r_reg0 <= w_head_data;
      end
   end

   assign r0 = r_reg0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg1 <= '0;
         r_reg2 <= '0;
         r_reg3 <= '0;
      end else if (w_pop) begin
         case (w_head_sel)
            REG_R1:  r_reg1 <= w_head_data;
            REG_R2:  r_reg2 <= w_head_data;
            REG_R3:  r_reg3 <= w_head_data;
            default: ;
         endcase
      end
   end

   assign r1 = r_reg1;
   assign r2 = r_reg2;
   assign r3 = r_reg3;

   // busy is the OR of decoded selects over live entries only.
   always_comb begin
      w_busy = 4'b0000;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_ent_vld[k]) w_busy = w_busy | sel_onehot(w_ent_sel[k]);
      end
`ifdef REG_WB_R0_ZERO_EN
      w_busy[0] = 1'b0;
`endif
   end

   assign busy = w_busy;

endmodule
